// File: rtl/ay_psg_responder.sv
// AY PSG responder: decodes BDIR/BC1 bus cycles into a 16-entry register
// file, returns read data to the CPU path, and runs three tone channels
// plus a noise LFSR off the divided ay_clk to feed the internal mixer.
module ay_psg_responder #(
  parameter logic [3:0]  CHIP_SEL   = 4'h0,
  parameter logic [16:0] NOISE_SEED = 17'h00001
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       ay_clk,
  input  logic       bdir,
  input  logic       bc1,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_out_active,
  output logic [2:0] chan,
  output logic [4:0] vol_a,
  output logic [4:0] vol_b,
  output logic [4:0] vol_c
);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_LATCH = 2'b11
  } bus_e;

  bus_e bus;
  assign bus = bus_e'({bdir, bc1});

  // Register file and bus-side state
  logic [7:0]  regs_q [16];
  logic [3:0]  addr_q, addr_d;
  logic        sel_q, sel_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        commit;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_out_active_q;

  // Sound generation state
  logic        ay_prev_q;
  logic        tick, step;
  logic [2:0]  presc_q, presc_d;
  logic [11:0] tp [3];
  logic [11:0] tcnt_q [3];
  logic [11:0] tcnt_d [3];
  logic [2:0]  tone_q, tone_d;
  logic        ndiv_q, ndiv_d;
  logic [4:0]  ncnt_q, ncnt_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [2:0]  chan_q, chan_d;

  // Unused upper bits of narrow registers are forced to zero on write.
  function automatic logic [7:0] mask_reg(input logic [3:0] a, input logic [7:0] v);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: mask_reg = {4'h0, v[3:0]};
      4'd6, 4'd8, 4'd9, 4'd10: mask_reg = {3'b000, v[4:0]};
      default:                 mask_reg = v;
    endcase
  endfunction

  // Counter expiry: compared at 13 bits so cnt+1 never wraps; period 0 acts as 1.
  function automatic logic period_done(input logic [11:0] cnt, input logic [11:0] per);
    logic [12:0] lim;
    lim = (per == 12'd0) ? 13'd1 : {1'b0, per};
    period_done = ({1'b0, cnt} + 13'd1) >= lim;
  endfunction

  assign tp[0] = {regs_q[1][3:0], regs_q[0]};
  assign tp[1] = {regs_q[3][3:0], regs_q[2]};
  assign tp[2] = {regs_q[5][3:0], regs_q[4]};

  // Bus decode: latch address/select, capture write data, commit on write exit.
  // The commit uses the current addr/sel, so a WRITE->LATCH hand-off still
  // lands in the old register while the new address takes effect next cycle.
  always_comb begin
    addr_d    = addr_q;
    sel_d     = sel_q;
    wr_pend_d = wr_pend_q;
    wr_data_d = wr_data_q;
    commit    = 1'b0;
    if (wr_pend_q && (bus != BUS_WRITE)) begin
      commit    = sel_q;
      wr_pend_d = 1'b0;
    end
    case (bus)
      BUS_LATCH: begin
        addr_d = d_in[3:0];
        sel_d  = (d_in[7:4] == CHIP_SEL);
      end
      BUS_WRITE: begin
        wr_data_d = d_in;
        wr_pend_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus-side state registers
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      sel_q     <= 1'b1;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file: masked commit of the last captured write value
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[addr_q] <= mask_reg(addr_q, wr_data_q);
    end
  end

  // Read data: refreshed every READ cycle, held otherwise
  always_comb begin
    d_out_d = d_out_q;
    if (bus == BUS_READ) d_out_d = sel_q ? regs_q[addr_q] : 8'hFF;
  end

  // Read data and its valid flag, both one clk28 behind the bus
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q        <= 8'hFF;
      d_out_active_q <= 1'b0;
    end else begin
      d_out_q        <= d_out_d;
      d_out_active_q <= (bus == BUS_READ);
    end
  end

  assign tick = ay_clk & ~ay_prev_q;
  assign step = tick & (presc_q == 3'd7);

  // Prescaler, tone counters, noise divider/counter, LFSR and mixer next state
  always_comb begin
    presc_d = tick ? presc_q + 3'd1 : presc_q;
    tone_d  = tone_q;
    ndiv_d  = ndiv_q;
    ncnt_d  = ncnt_q;
    lfsr_d  = lfsr_q;
    for (int unsigned k = 0; k < 3; k++) tcnt_d[k] = tcnt_q[k];
    if (step) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (period_done(tcnt_q[k], tp[k])) begin
          tcnt_d[k] = '0;
          tone_d[k] = ~tone_q[k];
        end else begin
          tcnt_d[k] = tcnt_q[k] + 12'd1;
        end
      end
      ndiv_d = ~ndiv_q;
      if (ndiv_q) begin
        if (period_done({7'd0, ncnt_q}, {7'd0, regs_q[6][4:0]})) begin
          ncnt_d = '0;
          lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
        end else begin
          ncnt_d = ncnt_q + 5'd1;
        end
      end
    end
    for (int unsigned k = 0; k < 3; k++)
      chan_d[k] = (tone_q[k] | regs_q[7][k]) & (lfsr_q[0] | regs_q[7][k + 3]);
  end

  // Sound generation state registers
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ay_prev_q <= 1'b0;
      presc_q   <= '0;
      for (int unsigned k = 0; k < 3; k++) tcnt_q[k] <= '0;
      tone_q    <= '0;
      ndiv_q    <= 1'b0;
      ncnt_q    <= '0;
      lfsr_q    <= NOISE_SEED;
      chan_q    <= '0;
    end else begin
      ay_prev_q <= ay_clk;
      presc_q   <= presc_d;
      for (int unsigned k = 0; k < 3; k++) tcnt_q[k] <= tcnt_d[k];
      tone_q    <= tone_d;
      ndiv_q    <= ndiv_d;
      ncnt_q    <= ncnt_d;
      lfsr_q    <= lfsr_d;
      chan_q    <= chan_d;
    end
  end

  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;
  assign chan         = chan_q;
  assign vol_a        = regs_q[8][4:0];
  assign vol_b        = regs_q[9][4:0];
  assign vol_c        = regs_q[10][4:0];

endmodule

// File: tb/tb_ay_psg_responder.sv
// Bench for ay_psg_responder: a behavioural model of the PSG compared with
// the DUT on every clk28, plus directed bus and sound scenarios.
module tb_ay_psg_responder;

  localparam logic [16:0] SEED = 17'h00001;

  logic       rst_n = 1'b0;
  logic       clk28 = 1'b0;
  logic       ay_clk = 1'b0;
  logic       bdir = 1'b0;
  logic       bc1 = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_out_active;
  logic [2:0] chan;
  logic [4:0] vol_a, vol_b, vol_c;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int          ay_div = 0;

  ay_psg_responder #(.CHIP_SEL(4'h0), .NOISE_SEED(SEED)) dut (
    .rst_n(rst_n), .clk28(clk28), .ay_clk(ay_clk), .bdir(bdir), .bc1(bc1),
    .d_in(d_in), .d_out(d_out), .d_out_active(d_out_active), .chan(chan),
    .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c)
  );

  always #5 clk28 = ~clk28;

  // ay_clk level toggled every ay_div clk28 cycles (0 = stopped)
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk28);
      if (ay_div != 0) begin
        c++;
        if (c >= ay_div) begin
          ay_clk = ~ay_clk;
          c = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mr [16];
  logic [3:0]  ma;
  logic        msel, mpend, mdact, mprev, mnpar;
  logic [7:0]  mwd, mdout;
  logic [2:0]  mchan, mtone, nc;
  logic [16:0] mlfsr;
  logic [16:0] mhist [32];
  int          mticks, mnsince, mshifts;
  int          msince [3];

  function automatic logic [7:0] width_mask(input int a, input logic [7:0] v);
    if (a == 1 || a == 3 || a == 5 || a == 13) return v & 8'h0F;
    if (a == 6 || a == 8 || a == 9 || a == 10) return v & 8'h1F;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 8'h00;
    ma = 4'h0; msel = 1'b1; mpend = 1'b0; mwd = 8'h00;
    mdout = 8'hFF; mdact = 1'b0; mchan = 3'b000; mtone = 3'b000;
    mprev = 1'b0; mticks = 0; mnpar = 1'b0; mnsince = 0;
    for (int k = 0; k < 3; k++) msince[k] = 0;
    mlfsr = SEED; mshifts = 0;
    for (int i = 0; i < 32; i++) mhist[i] = 17'h0;
    mhist[0] = SEED;
  endtask

  task automatic model_clock();
    bit tick, step;
    int per;
    // mixer, read path and sound all see the pre-edge register values
    for (int k = 0; k < 3; k++)
      nc[k] = (mtone[k] | mr[7][k]) & (mlfsr[0] | mr[7][k + 3]);
    if (!bdir && bc1) begin
      mdout = msel ? mr[ma] : 8'hFF;
      mdact = 1'b1;
    end else begin
      mdact = 1'b0;
    end
    tick = ay_clk && !mprev;
    mprev = ay_clk;
    step = tick && (mticks % 8 == 7);
    if (tick) mticks++;
    if (step) begin
      for (int k = 0; k < 3; k++) begin
        per = {mr[2 * k + 1][3:0], mr[2 * k]};
        if (per == 0) per = 1;
        if (msince[k] + 1 >= per) begin
          msince[k] = 0;
          mtone[k] = ~mtone[k];
        end else begin
          msince[k]++;
        end
      end
      if (mnpar) begin
        per = mr[6][4:0];
        if (per == 0) per = 1;
        if (mnsince + 1 >= per) begin
          mnsince = 0;
          mlfsr = {mlfsr[0] ^ mlfsr[3], mlfsr[16:1]};
          mshifts++;
          if (mshifts < 32) mhist[mshifts] = mlfsr;
        end else begin
          mnsince++;
        end
      end
      mnpar = !mnpar;
    end
    if (mpend && !(bdir && !bc1)) begin
      if (msel) mr[ma] = width_mask(ma, mwd);
      mpend = 1'b0;
    end
    if (bdir && !bc1) begin
      mwd = d_in;
      mpend = 1'b1;
    end
    if (bdir && bc1) begin
      ma = d_in[3:0];
      msel = (d_in[7:4] == 4'h0);
    end
    mchan = nc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk28 or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock();
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk28);
      chk("d_out", d_out, mdout);
      chk("d_out_active", d_out_active, mdact);
      chk("chan", chan, mchan);
      chk("vol_a", vol_a, mr[8][4:0]);
      chk("vol_b", vol_b, mr[9][4:0]);
      chk("vol_c", vol_c, mr[10][4:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic b, input logic c, input logic [7:0] d);
    @(negedge clk28);
    bdir = b; bc1 = c; d_in = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    cyc(1'b1, 1'b1, {4'h0, a});
    cyc(1'b1, 1'b0, v);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] lb, input logic [7:0] exp, input string nm);
    cyc(1'b1, 1'b1, lb);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    chk(nm, d_out, exp);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic edge_gap(input int limit, output int gap);
    logic p;
    bit seen;
    p = chan[0];
    gap = 0;
    seen = 0;
    while (!seen && gap < limit) begin
      @(negedge clk28);
      gap++;
      if (chan[0] !== p) seen = 1;
    end
    if (!seen) gap = limit;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int g, n;
    repeat (3) @(negedge clk28);
    #2 rst_n = 1'b1;
    @(negedge clk28);
    @(negedge clk28);
    chk("rst_d_out", d_out, 8'hFF);
    chk("rst_d_out_active", d_out_active, 1'b0);
    chk("rst_chan", chan, 3'b000);
    chk("rst_vols", {vol_a, vol_b, vol_c}, 15'h0);
    for (int i = 0; i < 16; i++) rd(8'(i), 8'h00, $sformatf("rst_read_R%0d", i));

    // 4-bit mask and d_out_active timing
    wr(4'd1, 8'hFF);
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h00);
    chk("act_before", d_out_active, 1'b0);
    @(negedge clk28);
    chk("act_rise", d_out_active, 1'b1);
    chk("r1_mask", d_out, 8'h0F);
    bdir = 1'b0; bc1 = 1'b0;
    @(negedge clk28);
    chk("act_fall", d_out_active, 1'b0);

    // deselected chip ignores writes, reads FF
    cyc(1'b1, 1'b1, 8'h17);
    cyc(1'b1, 1'b0, 8'hAA);
    cyc(1'b0, 1'b0, 8'h00);
    rd(8'h07, 8'h00, "unsel_write_ignored");
    rd(8'h17, 8'hFF, "unsel_read_ff");

    // WRITE->LATCH commits to old address
    cyc(1'b1, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b1, 8'h03);
    cyc(1'b0, 1'b0, 8'h00);
    rd(8'h02, 8'h55, "wl_old_addr");
    rd(8'h03, 8'h00, "wl_new_addr");

    // volume pass-through and 5-bit mask
    wr(4'd8, 8'h1F);
    wr(4'd9, 8'h3F);
    wr(4'd10, 8'hF0);
    @(negedge clk28);
    chk("vol_a_lit", vol_a, 5'h1F);
    chk("vol_b_lit", vol_b, 5'h1F);
    chk("vol_c_lit", vol_c, 5'h10);
    rd(8'h09, 8'h1F, "r9_mask");

    // reset with a write pending discards it
    cyc(1'b1, 1'b1, 8'h04);
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    @(negedge clk28);
    #2 rst_n = 1'b1;
    rd(8'h00, 8'h00, "pend_discard_R0");
    rd(8'h04, 8'h00, "pend_discard_R4");

    // tone A, TP=2: toggles every 2 steps = 128 clk28
    ay_div = 4;
    wr(4'd7, 8'hFE);
    wr(4'd1, 8'h00);
    wr(4'd0, 8'h02);
    edge_gap(400, g);
    chk("tp2_sync", g < 400, 1'b1);
    edge_gap(400, g);
    chk("tp2_period", g, 128);
    chk("tp2_bc", chan[2:1], 2'b11);

    // TP=0 behaves as TP=1
    wr(4'd0, 8'h00);
    edge_gap(400, g);
    edge_gap(400, g);
    chk("tp0_period", g, 64);

    // lowering TP below the count resets on the next step
    wr(4'd0, 8'h0A);
    edge_gap(1000, g);
    chk("tp10_sync", g < 1000, 1'b1);
    repeat (330) @(negedge clk28);
    wr(4'd0, 8'h01);
    edge_gap(200, g);
    chk("tp_lower_gap", g <= 64, 1'b1);

    // noise: fresh LFSR, chan[0] follows lfsr[0]
    ay_div = 1;
    @(negedge clk28);
    #2 rst_n = 1'b0;
    @(negedge clk28);
    #2 rst_n = 1'b1;
    wr(4'd6, 8'h01);
    wr(4'd7, 8'hF7);
    n = 0;
    while (mshifts < 17 && n < 2000) begin
      @(negedge clk28);
      n++;
    end
    chk("noise_shift_budget", n < 2000, 1'b1);
    chk("lfsr_shift1", mhist[1], 17'h10000);
    chk("lfsr_shift8", mhist[8], 17'h00200);
    chk("lfsr_shift17", mhist[17], 17'h04001);
    repeat (3) @(negedge clk28);
    chk("noise_chan_high", chan, 3'b111);

    @(negedge clk28);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ay_psg_responder.md
Name: ay_psg_responder

Overview:
- PSG-side responder for the BDIR/BC1 bus driven by the CPLD AY interface.
- Decodes the bus cycles (latch address / write / read) into a 16-entry register file.
- Drives read data back onto the CPU data path.
- Generates three tone channels and a noise source, clocked by the divided ay_clk.
- Feeds the internal DAC/mixer when no external AY chip is fitted.

Parameters:
- CHIP_SEL, 4'h0: required value of address-latch bits [7:4] for this chip to be selected.
- NOISE_SEED, 17'h00001: LFSR reset value. Must be nonzero.

Ports:
- rst_n  in  1  asynchronous reset, active low
- clk28  in  1  28 MHz system clock
- ay_clk  in  1  PSG clock level, toggled in the clk28 domain
- bdir  in  1  bus direction from the AY interface
- bc1  in  1  bus control from the AY interface
- d_in  in  8  CPU data bus
- d_out  out  8  register read data
- d_out_active  out  1  d_out valid; drives the CPU data mux
- chan  out  3  mixed channel outputs: [0]=A, [1]=B, [2]=C
- vol_a  out  5  R8[4:0]
- vol_b  out  5  R9[4:0]
- vol_c  out  5  R10[4:0]

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk28. All inputs are synchronous to clk28; no synchronisers are used.
- Bus decode per clk28 cycle:
  - bdir=1, bc1=1: LATCH.
  - bdir=1, bc1=0: WRITE.
  - bdir=0, bc1=1: READ.
  - bdir=0, bc1=0: IDLE.
- LATCH:
  - Every active cycle: addr <= d_in[3:0].
  - sel <= (d_in[7:4] == CHIP_SEL).
  - The last cycle before exit wins.
- WRITE:
  - d_in is captured every active cycle.
  - Commit to reg[addr] happens on the first non-WRITE cycle, using the last captured value, only if sel=1.
  - If the bus goes WRITE->LATCH directly, the commit still uses the old addr; the new addr applies from the next cycle.
- Register width masks, applied on write:
  - R1, R3, R5, R13: 4 bits.
  - R6, R8, R9, R10: 5 bits.
  - All other registers: 8 bits.
  - Unused upper bits read back as 0.
- READ:
  - d_out <= sel ? reg[addr] : 8'hFF, registered.
  - d_out_active <= 1 one clk28 after READ is first seen.
  - d_out_active drops one clk28 after READ ends.
  - A WRITE commit to the same register is visible to a read starting in the next cycle.
- Reset values:
  - All 16 registers: 0. addr = 0, sel = 1.
  - d_out = 8'hFF, d_out_active = 0.
  - Tone counters and outputs: 0. Prescaler: 0. LFSR: NOISE_SEED.
  - chan = 3'b000 (registered output, updates one cycle after reset release).
  - vol_a/b/c = 0.
- Tick:
  - tick = rising edge of ay_clk, from a registered previous value (ay_clk_prev reset 0).
  - 3-bit prescaler increments on each tick.
  - step = tick while prescaler == 7 (one step per 8 ticks).
- Tone x (A/B/C), with TP = {R(2x+1)[3:0], R(2x)}, 12 bits:
  - On step: if cnt+1 >= max(TP,1), then cnt <= 0 and tone_x toggles; else cnt <= cnt+1.
  - Compare at 13 bits to avoid wrap.
  - TP = 0 behaves as TP = 1.
  - Lowering TP below cnt resets cnt on the next step; there is no wrap through 4095.
- Noise:
  - Uses a second-level divider: a 1-bit toggle on each step.
  - Noise counter (5 bits) advances on steps where that toggle was 1, with period max(R6,1) and the same compare rule as tone.
  - On expiry: lfsr <= {lfsr[0]^lfsr[3], lfsr[16:1]}.
  - noise = lfsr[0].
- Mixer, registered every clk28: chan[x] = (tone_x | R7[x]) & (noise | R7[x+3]).
- Envelope:
  - R11, R12 and R13 are stored and readable only; no envelope is generated.
  - vol_x[4] is passed through unchanged.
- Simultaneous commit and step in the same cycle: the step uses the old register value; the new value takes effect on the next step.
- Reset asserted mid-operation clears all state immediately, including any pending write commit (discarded).

Test Plan:
- Reset release -> d_out=FF, d_out_active=0, chan=000, all volumes 0. Read of R0..R15 -> 00.
- LATCH 8'h01, WRITE 8'hFF, then READ -> d_out=8'h0F (4-bit mask). d_out_active rises 1 clk after bc1 and falls 1 clk after bc1 drops.
- LATCH 8'h17 (sel=0), WRITE 8'hAA, LATCH 8'h07, READ -> 8'h00; a READ while sel=0 returns 8'hFF.
- R0=2, R1=0, R7=8'hFE, ay_clk toggled every 4 clk28 -> chan[0] toggles every 2 steps = 16 ay_clk rises; chan[2:1]=11.
- R0=0, R1=0 -> chan[0] toggles every step (same as TP=1). Writing R0=1 while cnt=5 after TP=10 -> counter resets on the next step, no long gap.
- R6=1, R7=8'hF7 -> chan[0] follows lfsr[0]. First 8 noise shifts from seed 1 match the tap model (bit0^bit3 into bit16).
